// File: rtl/core_bus_arbiter_pkg.sv
// Shared types for the ibus/dbus arbiter and its outstanding-transfer counter.
package core_bus_arbiter_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} arb_state_t;
  typedef enum logic {ARB_M0, ARB_M1} arb_master_t;

  // Request payload that is steered from the granted master to the shared bus.
  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_w;
    logic [SEL_W-1:0] sel;
  } wb_req_t;

endpackage

// File: rtl/core_bus_arbiter_outst_cnt.sv
// Counts accepted-but-unacknowledged pipelined bus transfers.
module core_outst_cnt #(
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             done,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  logic dec;

  // A completion with nothing outstanding is a stray and must not underflow.
  assign dec  = done & (cnt != '0);
  assign full = (cnt == CNT_W'(MAX_OUTST));

  // Counter update; clear wins, simultaneous accept and completion cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (accept && !dec) begin
      cnt <= cnt + CNT_W'(1);
    end else if (!accept && dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Merges the ibus (master 0) and dbus (master 1) pipelined wishbone ports onto one.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_cyc,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [DAT_W-1:0] m0_dat_w,
  input  logic [SEL_W-1:0] m0_sel,
  output logic [DAT_W-1:0] m0_dat_r,
  output logic             m0_ack,
  output logic             m0_err,
  output logic             m0_stall,
  input  logic             m1_cyc,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [DAT_W-1:0] m1_dat_w,
  input  logic [SEL_W-1:0] m1_sel,
  output logic [DAT_W-1:0] m1_dat_r,
  output logic             m1_ack,
  output logic             m1_err,
  output logic             m1_stall,
  output logic             s_cyc,
  output logic             s_stb,
  output logic             s_we,
  output logic [ADR_W-1:0] s_adr,
  output logic [DAT_W-1:0] s_dat_w,
  output logic [SEL_W-1:0] s_sel,
  input  logic [DAT_W-1:0] s_dat_r,
  input  logic             s_ack,
  input  logic             s_err,
  input  logic             s_stall
);

  arb_state_t       state;
  arb_master_t      last;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             granted;
  logic             gnt_i;
  logic             gnt_d;
  logic             g_cyc;
  logic             g_stb;
  logic             g_stall;
  logic             fwd;
  wb_req_t          m0_req;
  wb_req_t          m1_req;
  wb_req_t          g_req;

  assign gnt_i   = (state == ARB_GNT_I);
  assign gnt_d   = (state == ARB_GNT_D);
  assign granted = gnt_i | gnt_d;

  assign m0_req = '{we: m0_we, adr: m0_adr, dat_w: m0_dat_w, sel: m0_sel};
  assign m1_req = '{we: m1_we, adr: m1_adr, dat_w: m1_dat_w, sel: m1_sel};

  // Combinational pass-through of the granted master onto the shared bus.
  assign g_cyc = gnt_d ? m1_cyc : m0_cyc;
  assign g_stb = gnt_d ? m1_stb : m0_stb;
  assign g_req = gnt_d ? m1_req : m0_req;

  assign s_cyc   = granted & g_cyc;
  assign s_stb   = granted & g_cyc & g_stb & ~full;
  assign s_we    = g_req.we;
  assign s_adr   = g_req.adr;
  assign s_dat_w = g_req.dat_w;
  assign s_sel   = g_req.sel;

  // Responses only reach the owner, and only while something is outstanding.
  assign g_stall  = s_stall | full;
  assign fwd      = granted & (cnt != '0);
  assign m0_stall = gnt_i ? g_stall : 1'b1;
  assign m1_stall = gnt_d ? g_stall : 1'b1;
  assign m0_ack   = gnt_i & fwd & s_ack;
  assign m1_ack   = gnt_d & fwd & s_ack;
  assign m0_err   = gnt_i & fwd & s_err;
  assign m1_err   = gnt_d & fwd & s_err;
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

  // Outstanding transfers of the current owner; dropped cyc abandons them.
  core_outst_cnt #(
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) u_outst_cnt (
    .clk    (clk),
    .rst    (rst),
    .accept (s_stb & ~s_stall),
    .done   (s_ack | s_err),
    .clear  (granted & ~g_cyc),
    .cnt    (cnt),
    .full   (full)
  );

  // Grant FSM: locked while owner holds cyc, every handoff passes through idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      last  <= ARB_M0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (m0_cyc && m1_cyc) begin
            state <= (last == ARB_M0) ? ARB_GNT_D : ARB_GNT_I;
          end else if (m0_cyc) begin
            state <= ARB_GNT_I;
          end else if (m1_cyc) begin
            state <= ARB_GNT_D;
          end
        end
        ARB_GNT_I: begin
          if (!m0_cyc) begin
            state <= ARB_IDLE;
            last  <= ARB_M0;
          end
        end
        ARB_GNT_D: begin
          if (!m1_cyc) begin
            state <= ARB_IDLE;
            last  <= ARB_M1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Self-checking bench for core_bus_arbiter: vector table, corner sequences, random vs model.
module tb_core_bus_arbiter;

  localparam int MAX_OUTST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat_w;
  logic [3:0]  m0_sel;
  logic [31:0] m0_dat_r;
  logic        m0_ack, m0_err, m0_stall;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat_w;
  logic [3:0]  m1_sel;
  logic [31:0] m1_dat_r;
  logic        m1_ack, m1_err, m1_stall;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_w;
  logic [3:0]  s_sel;
  logic [31:0] s_dat_r;
  logic        s_ack, s_err, s_stall;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: current owner (-1 none), previous owner, outstanding count.
  int owner;
  int last_m;
  int outst;

  core_bus_arbiter #(.MAX_OUTST(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_dat_r(m0_dat_r),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_stall(m0_stall),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_dat_r(m1_dat_r),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_stall(m1_stall),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_sel(s_sel), .s_dat_r(s_dat_r),
    .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic m0c, m0s, m1c, m1s, ack;
    logic e_cyc, e_stb, e_st0, e_st1, e_ack0, e_ack1;
  } vec_t;

  vec_t tv[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    owner  = -1;
    last_m = 0;
    outst  = 0;
  endtask

  // Compare every DUT output against what the arbitration rules require right now.
  task automatic model_check();
    logic c[2];
    logic st[2], ak[2], er[2];
    logic full;
    logic [31:0] ea, ed;
    logic [3:0]  es;
    logic        ew;
    c[0] = m0_cyc;  c[1] = m1_cyc;
    st[0] = m0_stall; st[1] = m1_stall;
    ak[0] = m0_ack; ak[1] = m1_ack;
    er[0] = m0_err; er[1] = m1_err;
    full = (outst == MAX_OUTST);
    check("m0_dat_r", m0_dat_r, s_dat_r);
    check("m1_dat_r", m1_dat_r, s_dat_r);
    check("s_cyc", 32'(s_cyc), (owner >= 0) ? 32'(c[owner]) : 32'd0);
    check("s_stb", 32'(s_stb),
          (owner >= 0) ? 32'(c[owner] & (owner == 0 ? m0_stb : m1_stb) & ~full) : 32'd0);
    for (int m = 0; m < 2; m++) begin
      check("stall", 32'(st[m]), (m == owner) ? 32'(s_stall | full) : 32'd1);
      check("ack", 32'(ak[m]), (m == owner && outst > 0) ? 32'(s_ack) : 32'd0);
      check("err", 32'(er[m]), (m == owner && outst > 0) ? 32'(s_err) : 32'd0);
    end
    if (owner >= 0) begin
      ea = owner == 1 ? m1_adr : m0_adr;
      ed = owner == 1 ? m1_dat_w : m0_dat_w;
      es = owner == 1 ? m1_sel : m0_sel;
      ew = owner == 1 ? m1_we : m0_we;
      check("s_adr", s_adr, ea);
      check("s_dat_w", s_dat_w, ed);
      check("s_sel", 32'(s_sel), 32'(es));
      check("s_we", 32'(s_we), 32'(ew));
    end
  endtask

  // Advance the model by the clock edge that is about to sample the current inputs.
  task automatic model_update();
    logic c[2], s[2];
    logic acc, dn;
    c[0] = m0_cyc; c[1] = m1_cyc;
    s[0] = m0_stb; s[1] = m1_stb;
    if (owner < 0) begin
      if (c[0] && c[1]) owner = (last_m == 0) ? 1 : 0;
      else if (c[0]) owner = 0;
      else if (c[1]) owner = 1;
    end else if (!c[owner]) begin
      last_m = owner;
      owner  = -1;
      outst  = 0;
    end else begin
      acc = s[owner] && (outst < MAX_OUTST) && !s_stall;
      dn  = (s_ack || s_err) && (outst > 0);
      outst = outst + int'(acc) - int'(dn);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic end_cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    at_neg();
    end_cycle();
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 32'h0000_0100; m0_dat_w = 32'h0; m0_sel = 4'hf;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 32'h0000_1000; m1_dat_w = 32'h0; m1_sel = 4'hf;
    s_dat_r = 32'h0; s_ack = 0; s_err = 0; s_stall = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1;
  endtask

  int acc_cnt;
  int k;

  initial begin
    // Reset held with ibus requesting: nothing may leak out.
    rst = 0;
    clear_inputs();
    m0_cyc = 1; m0_stb = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_s_cyc", 32'(s_cyc), 32'd0);
      check("rst_s_stb", 32'(s_stb), 32'd0);
      check("rst_m0_stall", 32'(m0_stall), 32'd1);
      check("rst_m0_ack", 32'(m0_ack), 32'd0);
    end
    @(posedge clk);
    #1;
    model_reset();
    rst = 1;
    step();
    at_neg();
    check("post_rst_s_stb", 32'(s_stb), 32'd1);
    end_cycle();

    // Vector table: simultaneous requests, round-robin handoff, late ack.
    tv[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      m0_cyc = tv[i].m0c; m0_stb = tv[i].m0s;
      m1_cyc = tv[i].m1c; m1_stb = tv[i].m1s;
      s_ack  = tv[i].ack;
      at_neg();
      check($sformatf("tv%0d_s_cyc", i), 32'(s_cyc), 32'(tv[i].e_cyc));
      check($sformatf("tv%0d_s_stb", i), 32'(s_stb), 32'(tv[i].e_stb));
      check($sformatf("tv%0d_m0_stall", i), 32'(m0_stall), 32'(tv[i].e_st0));
      check($sformatf("tv%0d_m1_stall", i), 32'(m1_stall), 32'(tv[i].e_st1));
      check($sformatf("tv%0d_m0_ack", i), 32'(m0_ack), 32'(tv[i].e_ack0));
      check($sformatf("tv%0d_m1_ack", i), 32'(m1_ack), 32'(tv[i].e_ack1));
      end_cycle();
    end

    // Pipelining limit: six back-to-back dbus strobes, no acks.
    do_reset();
    m1_cyc = 1;
    step();
    acc_cnt = 0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      m1_stb = (k < 6);
      m1_adr = 32'h0000_1000 + 32'(4 * k);
      at_neg();
      if (m1_stb && !m1_stall) begin
        acc_cnt++;
        k++;
      end
      end_cycle();
    end
    check("pipe_accepted", 32'(acc_cnt), 32'd4);
    at_neg();
    check("pipe_full_stall", 32'(m1_stall), 32'd1);
    check("pipe_full_stb", 32'(s_stb), 32'd0);
    s_ack = 1;
    end_cycle();
    s_ack = 0;
    at_neg();
    check("pipe_5th_stall", 32'(m1_stall), 32'd0);
    check("pipe_5th_stb", 32'(s_stb), 32'd1);
    check("pipe_5th_adr", s_adr, 32'h0000_1010);
    end_cycle();
    m1_adr = 32'h0000_1014;
    at_neg();
    check("pipe_refull_stall", 32'(m1_stall), 32'd1);
    end_cycle();
    m1_stb = 0; m1_cyc = 0;
    step();

    // Concurrent accept and ack at cnt=2, then exactly two more acks are forwarded.
    do_reset();
    m1_cyc = 1;
    step();
    m1_stb = 1; m1_adr = 32'h0000_2000;
    step();
    m1_adr = 32'h0000_2004;
    step();
    m1_adr = 32'h0000_2008; s_ack = 1; s_dat_r = 32'hDEAD_BEEF;
    at_neg();
    check("cc_m1_ack", 32'(m1_ack), 32'd1);
    check("cc_m1_dat_r", m1_dat_r, 32'hDEAD_BEEF);
    check("cc_s_stb", 32'(s_stb), 32'd1);
    end_cycle();
    m1_stb = 0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check($sformatf("cc_drain%0d_ack", i), 32'(m1_ack), (i < 2) ? 32'd1 : 32'd0);
      end_cycle();
    end
    s_ack = 0; m1_cyc = 0;
    step();

    // Abort with three outstanding; later acks are swallowed.
    do_reset();
    m0_cyc = 1;
    step();
    m0_stb = 1;
    repeat (3) step();
    m0_stb = 0; m0_cyc = 0;
    step();
    s_ack = 1;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      check("abort_m0_ack", 32'(m0_ack), 32'd0);
      check("abort_m1_ack", 32'(m1_ack), 32'd0);
      check("abort_s_cyc", 32'(s_cyc), 32'd0);
      end_cycle();
    end
    s_ack = 0;

    // Error on the second of two dbus reads.
    do_reset();
    m1_cyc = 1; m1_we = 0;
    step();
    m1_stb = 1;
    repeat (2) step();
    m1_stb = 0; s_ack = 1;
    at_neg();
    check("err_rd1_ack", 32'(m1_ack), 32'd1);
    check("err_rd1_err", 32'(m1_err), 32'd0);
    end_cycle();
    s_ack = 0; s_err = 1;
    at_neg();
    check("err_rd2_err", 32'(m1_err), 32'd1);
    check("err_rd2_ack", 32'(m1_ack), 32'd0);
    check("err_m0_ack", 32'(m0_ack), 32'd0);
    check("err_m0_err", 32'(m0_err), 32'd0);
    end_cycle();
    s_err = 0; s_ack = 1;
    at_neg();
    check("err_after_ack", 32'(m1_ack), 32'd0);
    end_cycle();
    s_ack = 0; m1_cyc = 0;
    step();

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 7) == 0) m1_cyc = ~m1_cyc;
      m0_stb   = m0_cyc & ($urandom_range(0, 1) == 1);
      m1_stb   = m1_cyc & ($urandom_range(0, 1) == 1);
      m0_we    = $urandom_range(0, 1) == 1;
      m1_we    = $urandom_range(0, 1) == 1;
      m0_adr   = $urandom;
      m1_adr   = $urandom;
      m0_dat_w = $urandom;
      m1_dat_w = $urandom;
      m0_sel   = 4'($urandom);
      m1_sel   = 4'($urandom);
      s_dat_r  = $urandom;
      s_stall  = $urandom_range(0, 3) == 0;
      s_ack    = $urandom_range(0, 2) == 0;
      s_err    = !s_ack && ($urandom_range(0, 15) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Sits directly downstream of core_cpu and merges its two pipelined wishbone master ports, ibus (instruction fetch, master 0) and dbus (load/store, master 1), onto one pipelined wishbone master port towards memory/interconnect.
- Implements a grant FSM with lock-while-cyc, round-robin handoff and an outstanding-transaction counter per grant.
- Routes ack, err and read data back only to the granted master.

Parameters:
- MAX_OUTST, default 4: maximum accepted-but-unacknowledged transfers. Range 1..15.
- CNT_W, default 4: width of the outstanding counter. Must satisfy 2^CNT_W > MAX_OUTST.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_cyc, m0_stb, m0_we  in  1 each  ibus master cycle, strobe and write enable.
- m0_adr, m0_dat_w  in  32 each  ibus address and write data.
- m0_sel  in  4  ibus byte select.
- m0_dat_r  out  32  ibus read data.
- m0_ack, m0_err, m0_stall  out  1 each  ibus ack, error and stall.
- m1_*  same set as m0_*  dbus master.
- s_cyc, s_stb, s_we  out  1 each  merged bus cycle, strobe and write enable.
- s_adr, s_dat_w  out  32 each  merged bus address and write data.
- s_sel  out  4  merged bus byte select.
- s_dat_r  in  32  merged bus read data.
- s_ack, s_err, s_stall  in  1 each  merged bus ack, error and stall.

Behaviour:
Clock and reset:
- One clock (clk). Reset (rst) is asynchronous and active-low.
- On rst low: state=IDLE, last=M0, cnt=0.
- Outputs during reset: s_cyc=0, s_stb=0; m0_stall=m1_stall=1; all acks and errs 0.
- A reset mid-transfer abandons the transfer; no ack is generated afterwards.

FSM states: IDLE, GNT_I, GNT_D.
- IDLE:
  - Only m0_cyc set -> GNT_I. Only m1_cyc set -> GNT_D.
  - Both set -> grant the master that is not `last`. After reset last=M0, so dbus wins.
  - The decision is registered. Both masters see stall=1 while in IDLE, so the first stb can be accepted 1 cycle after cyc rises, at the earliest.
- GNT_x, granted master g:
  - s_cyc=g_cyc; s_stb=g_stb & ~full; s_we, s_adr, s_dat_w and s_sel are passed through combinationally from g.
  - g_stall = s_stall | full, where full = (cnt==MAX_OUTST).
  - g_ack=s_ack and g_err=s_err when cnt!=0; g_dat_r=s_dat_r.
  - The non-granted master sees stall=1, ack=0, err=0 and dat_r=s_dat_r; its dat_r is don't-care.
- Grant lock: the grant holds while g_cyc=1. When g_cyc falls, the FSM goes to IDLE next cycle and sets last=g.
  - There is no direct GNT_I<->GNT_D transition. Every handoff passes through IDLE, which guarantees one idle cycle with s_cyc=0 between owners.

Outstanding counter cnt:
- Increments on s_stb & ~s_stall.
- Decrements on (s_ack|s_err) & cnt!=0.
- On a simultaneous accept and ack, cnt is unchanged.
- Saturation cannot occur because s_stb is gated by full.

Abort and error cases:
- If g_cyc drops with cnt>0, cnt is cleared to 0 on the next edge.
- Late acks are swallowed: they are not forwarded because cnt=0.
- An s_ack or s_err arriving with cnt=0 is ignored and has no effect.
- s_err is treated like ack for counting. It is forwarded as g_err, never as g_ack.

Decomposition:
- Add to i2d_core_defines.sv:
  - typedef enum logic[1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} arb_state_t;
  - typedef enum logic {ARB_M0, ARB_M1} arb_master_t.
- core_cpu instantiates the arbiter on its ibus/dbus outputs. The arbiter stays one module; the pass-through mux is combinational inside it.
- Reuse the same logic for the counter as a sub-module core_outst_cnt: inputs accept, done and clear; outputs cnt and full. The team's other pipelined-bus bridges need it too.

Test Plan:
- Reset: rst low for 3 cycles while m0_cyc=1 and m0_stb=1 -> s_cyc=0, m0_stall=1 and cnt=0 throughout. IDLE->GNT_I occurs on the first edge with rst high, and s_stb=1 one cycle later.
- Simultaneous request after reset: m0_cyc=m1_cyc=1 at cycle 0 -> GNT_D at cycle 1. m1 completes, then m1_cyc drops -> s_cyc=0 for 1 cycle, then GNT_I, last=M1. The next simultaneous request goes to m0.
- Pipelining limit (MAX_OUTST=4, s_ack held 0): m1 issues 6 back-to-back stb at 0x1000..0x1014 -> 4 accepted, m1_stall=1 from the 5th. One s_ack -> the 5th is accepted next cycle; cnt stays 4.
- Concurrent accept and ack: with cnt=2, s_stb accepted and s_ack in the same cycle -> cnt=2. m1_ack=1 and m1_dat_r=s_dat_r (0xDEADBEEF).
- Abort: GNT_I with cnt=3, m0_cyc dropped -> cnt=0 next cycle, FSM in IDLE. Two later s_ack pulses -> m0_ack=m1_ack=0.
- Error: s_err=1 on the 2nd of 2 dbus reads -> m1_ack on the 1st read, m1_err (not ack) on the 2nd, cnt returns to 0. m0 sees no ack or err.
